// File: rtl/alu_seq_pkg.sv
// Shared types and widths for the ALU/register-file command sequencer.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RR   = 2'd1,
        ST_EX   = 2'd2,
        ST_WB   = 2'd3
    } seq_state_t;

    localparam int ADDR_W_DEF = 5;
    localparam int OP_W_DEF   = 4;
    localparam int FLAG_W     = 4;

    // Buffered command word, MSB first: {a, b, w, op, we}
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] a;
        logic [ADDR_W_DEF-1:0] b;
        logic [ADDR_W_DEF-1:0] w;
        logic [OP_W_DEF-1:0]   op;
        logic                  we;
    } cmd_t;

    function automatic int cmd_width(input int addr_w, input int op_w);
        return 3 * addr_w + op_w + 1;
    endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit to tell full from empty.
module alu_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                     (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);
    assign dout    = mem[rd_ptr[IDX_W-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[IDX_W-1:0]] <= din;
    end

endmodule

// File: rtl/alu_regs_sequencer.sv
// Buffers ALU commands and runs each as RR -> EX -> WB with per-phase enable strobes.
// Optional ALU_SEQ_STEP_EN: phases advance only on rising edges of a synchronised step input.
//
// state | meaning
// IDLE  | no command in flight; pops the buffer head when one is present
// RR    | register read, rr_en high
// EX    | ALU execute, f_en high
// WB    | write-back, wb_en high if the command's we is set; done on last cycle
module alu_regs_sequencer
    import alu_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int OP_W       = OP_W_DEF,
    parameter int PHASE_CYC  = 1
) (
    input  logic              clk,
    input  logic              rst,
`ifdef ALU_SEQ_STEP_EN
    input  logic              step,
`endif
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_a,
    input  logic [ADDR_W-1:0] cmd_b,
    input  logic [ADDR_W-1:0] cmd_w,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic              cmd_we,
    output logic [ADDR_W-1:0] R_Addr_A,
    output logic [ADDR_W-1:0] R_Addr_B,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [OP_W-1:0]   ALU_OP,
    output logic              rr_en,
    output logic              f_en,
    output logic              wb_en,
    input  logic [FLAG_W-1:0] FR,
    output logic [FLAG_W-1:0] flags_q,
    output logic              busy,
    output logic              done
);
    localparam int CMD_W = cmd_width(ADDR_W, OP_W);
    localparam int CNT_W = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PHASE_CYC - 1);

    seq_state_t        state;
    logic [CNT_W-1:0]  phase_cnt;
    logic              we_q;
    logic              wb_first;
    logic              go;
    logic              phase_end;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CMD_W-1:0]  fifo_din;
    logic [CMD_W-1:0]  fifo_dout;
    logic [ADDR_W-1:0] head_a;
    logic [ADDR_W-1:0] head_b;
    logic [ADDR_W-1:0] head_w;
    logic [OP_W-1:0]   head_op;
    logic              head_we;

`ifdef ALU_SEQ_STEP_EN
    localparam bit STEP_MODE = 1'b1;
    logic step_meta;
    logic step_sync;
    logic step_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_meta <= 1'b0;
            step_sync <= 1'b0;
            step_prev <= 1'b0;
        end else begin
            step_meta <= step;
            step_sync <= step_meta;
            step_prev <= step_sync;
        end
    end

    assign go = step_sync && !step_prev;
`else
    localparam bit STEP_MODE = 1'b0;
    assign go = 1'b1;
`endif

    // In step mode a phase lasts until the next step edge; the cycle counter is idle.
    localparam bit DONE_ON_ENTRY = STEP_MODE || (PHASE_CYC == 1);

    assign phase_end = STEP_MODE ? go : (phase_cnt == '0);

    assign fifo_din = {cmd_a, cmd_b, cmd_w, cmd_op, cmd_we};
    assign head_a   = fifo_dout[CMD_W-1 -: ADDR_W];
    assign head_b   = fifo_dout[CMD_W-1-ADDR_W -: ADDR_W];
    assign head_w   = fifo_dout[OP_W+1 +: ADDR_W];
    assign head_op  = fifo_dout[1 +: OP_W];
    assign head_we  = fifo_dout[0];

    // full decodes straight from the pointer flops, so ready has no path from cmd_valid
    assign cmd_ready = !fifo_full;
    assign busy      = (state != ST_IDLE) || !fifo_empty;
    assign pop       = !fifo_empty &&
                       (((state == ST_IDLE) && go) || ((state == ST_WB) && phase_end));

    alu_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && cmd_ready),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            phase_cnt <= '0;
            rr_en     <= 1'b0;
            f_en      <= 1'b0;
            wb_en     <= 1'b0;
            done      <= 1'b0;
            we_q      <= 1'b0;
            wb_first  <= 1'b0;
            R_Addr_A  <= '0;
            R_Addr_B  <= '0;
            W_Addr    <= '0;
            ALU_OP    <= '0;
            flags_q   <= '0;
        end else begin
            done <= 1'b0;
            if (STEP_MODE) begin
                rr_en <= 1'b0;
                f_en  <= 1'b0;
                wb_en <= 1'b0;
            end
            if (pop) begin
                R_Addr_A <= head_a;
                R_Addr_B <= head_b;
                W_Addr   <= head_w;
                ALU_OP   <= head_op;
                we_q     <= head_we;
            end
            if (wb_first) begin
                flags_q  <= FR;
                wb_first <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state     <= ST_RR;
                        phase_cnt <= CNT_LOAD;
                        rr_en     <= 1'b1;
                    end
                end
                ST_RR: begin
                    if (phase_end) begin
                        state     <= ST_EX;
                        phase_cnt <= CNT_LOAD;
                        rr_en     <= 1'b0;
                        f_en      <= 1'b1;
                    end else if (!STEP_MODE) begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end
                ST_EX: begin
                    if (phase_end) begin
                        state     <= ST_WB;
                        phase_cnt <= CNT_LOAD;
                        f_en      <= 1'b0;
                        wb_en     <= we_q;
                        done      <= DONE_ON_ENTRY;
                        wb_first  <= 1'b1;
                    end else if (!STEP_MODE) begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end
                ST_WB: begin
                    if (phase_end) begin
                        wb_en <= 1'b0;
                        if (pop) begin
                            state     <= ST_RR;
                            phase_cnt <= CNT_LOAD;
                            rr_en     <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (!STEP_MODE) begin
                        phase_cnt <= phase_cnt - 1'b1;
                        if (phase_cnt == CNT_W'(1)) done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_regs_sequencer.sv
// Directed bench for alu_regs_sequencer: per-cycle vector table plus multi-cycle sequences.
module tb_alu_regs_sequencer;
    localparam int AW = 5;
    localparam int OW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [AW-1:0] cmd_a = '0;
    logic [AW-1:0] cmd_b = '0;
    logic [AW-1:0] cmd_w = '0;
    logic [OW-1:0] cmd_op = '0;
    logic          cmd_we = 1'b0;
    logic [3:0]    fr = '0;

    logic          rdy1, rr1, f1, wb1, busy1, done1;
    logic [AW-1:0] ra1, rb1, wa1;
    logic [OW-1:0] op1;
    logic [3:0]    fl1;

    logic          rdy3, rr3, f3, wb3, busy3, done3;
    logic [AW-1:0] ra3, rb3, wa3;
    logic [OW-1:0] op3;
    logic [3:0]    fl3;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_regs_sequencer #(.FIFO_DEPTH(4), .ADDR_W(AW), .OP_W(OW), .PHASE_CYC(1)) dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_w(cmd_w), .cmd_op(cmd_op), .cmd_we(cmd_we),
        .R_Addr_A(ra1), .R_Addr_B(rb1), .W_Addr(wa1), .ALU_OP(op1),
        .rr_en(rr1), .f_en(f1), .wb_en(wb1), .FR(fr), .flags_q(fl1),
        .busy(busy1), .done(done1)
    );

    alu_regs_sequencer #(.FIFO_DEPTH(4), .ADDR_W(AW), .OP_W(OW), .PHASE_CYC(3)) dut3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy3),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_w(cmd_w), .cmd_op(cmd_op), .cmd_we(cmd_we),
        .R_Addr_A(ra3), .R_Addr_B(rb3), .W_Addr(wa3), .ALU_OP(op3),
        .rr_en(rr3), .f_en(f3), .wb_en(wb3), .FR(fr), .flags_q(fl3),
        .busy(busy3), .done(done3)
    );

    typedef struct {
        logic          v;
        logic [AW-1:0] a, b, w;
        logic [OW-1:0] op;
        logic          we;
        logic [3:0]    fr;
        logic [5:0]    e_ctl;   // {rr, f, wb, done, busy, ready}
        logic [AW-1:0] e_a, e_b, e_w;
        logic [OW-1:0] e_op;
        logic [3:0]    e_fl;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(input int v, input int a, input int b, input int w,
                                input int op, input int we, input int frv, input int ctl,
                                input int ea, input int eb, input int ew, input int eop,
                                input int efl);
        vec_t r;
        r.v = 1'(v);  r.a = AW'(a); r.b = AW'(b); r.w = AW'(w);
        r.op = OW'(op); r.we = 1'(we); r.fr = 4'(frv); r.e_ctl = 6'(ctl);
        r.e_a = AW'(ea); r.e_b = AW'(eb); r.e_w = AW'(ew); r.e_op = OW'(eop);
        r.e_fl = 4'(efl);
        return r;
    endfunction

    function automatic logic [28:0] obs1();
        return {rr1, f1, wb1, done1, busy1, rdy1, ra1, rb1, wa1, op1, fl1};
    endfunction

    function automatic logic [28:0] obs3();
        return {rr3, f3, wb3, done3, busy3, rdy3, ra3, rb3, wa3, op3, fl3};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        cmd_valid = 1'b0;
        fr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drive_cmd(input int v, input int a, input int b, input int w,
                             input int op, input int we);
        cmd_valid = 1'(v);
        cmd_a = AW'(a); cmd_b = AW'(b); cmd_w = AW'(w);
        cmd_op = OW'(op); cmd_we = 1'(we);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Table: single we=1 command with FR=1010 during its WB, then a we=0 command
        vecs[0] = mk(1, 1, 2, 3, 0, 1, 0,  6'b000011, 0, 0, 0, 0, 0);
        vecs[1] = mk(0, 0, 0, 0, 0, 0, 0,  6'b100011, 1, 2, 3, 0, 0);
        vecs[2] = mk(0, 0, 0, 0, 0, 0, 0,  6'b010011, 1, 2, 3, 0, 0);
        vecs[3] = mk(0, 0, 0, 0, 0, 0, 0,  6'b001111, 1, 2, 3, 0, 0);
        vecs[4] = mk(0, 0, 0, 0, 0, 0, 10, 6'b000001, 1, 2, 3, 0, 10);
        vecs[5] = mk(1, 4, 5, 6, 9, 0, 0,  6'b000011, 1, 2, 3, 0, 10);
        vecs[6] = mk(0, 0, 0, 0, 0, 0, 0,  6'b100011, 4, 5, 6, 9, 10);
        vecs[7] = mk(0, 0, 0, 0, 0, 0, 0,  6'b010011, 4, 5, 6, 9, 10);
        vecs[8] = mk(0, 0, 0, 0, 0, 0, 0,  6'b000111, 4, 5, 6, 9, 10);
        vecs[9] = mk(0, 0, 0, 0, 0, 0, 5,  6'b000001, 4, 5, 6, 9, 5);

        repeat (2) @(negedge clk);
        check("reset_state_p1", 64'(obs1()), 64'({6'b000001, 23'd0}));
        check("reset_state_p3", 64'(obs3()), 64'({6'b000001, 23'd0}));
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive_cmd(int'(vecs[i].v), int'(vecs[i].a), int'(vecs[i].b), int'(vecs[i].w),
                      int'(vecs[i].op), int'(vecs[i].we));
            fr = vecs[i].fr;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d", i), 64'(obs1()),
                  64'({vecs[i].e_ctl, vecs[i].e_a, vecs[i].e_b, vecs[i].e_w,
                       vecs[i].e_op, vecs[i].e_fl}));
        end

        // Seven back-to-back commands into a depth-4 buffer
        begin
            int pushed = 0;
            int dones = 0;
            int last_done = -1;
            int first_low_at = -1;
            logic prev_v = 1'b0;
            logic prev_rdy = 1'b0;
            logic [18:0] expq[$];
            logic [18:0] exp_head;
            do_reset();
            for (int c = 0; c < 80 && dones < 7; c++) begin
                if (prev_v && prev_rdy) begin
                    expq.push_back({5'(pushed + 1), 5'(pushed + 9), 5'(pushed + 17),
                                    4'(pushed + 1)});
                    pushed++;
                end
                if (done1) begin
                    if (expq.size() == 0) begin
                        check("b2b_order_underflow", 64'(expq.size()), 64'(1));
                    end else begin
                        exp_head = expq.pop_front();
                        check("b2b_order", 64'({ra1, rb1, wa1, op1}), 64'(exp_head));
                    end
                    check("b2b_wb_with_done", 64'(wb1), 64'(1));
                    if (last_done >= 0) check("b2b_done_spacing", 64'(c - last_done), 64'(3));
                    last_done = c;
                    dones++;
                end
                if (!rdy1 && first_low_at < 0) first_low_at = pushed;
                if (pushed < 7) drive_cmd(1, pushed + 1, pushed + 9, pushed + 17, pushed + 1, 1);
                else drive_cmd(0, 0, 0, 0, 0, 0);
                prev_v = cmd_valid;
                prev_rdy = rdy1;
                @(posedge clk);
                @(negedge clk);
            end
            drive_cmd(0, 0, 0, 0, 0, 0);
            check("b2b_all_pushed", 64'(pushed), 64'(7));
            check("b2b_all_done", 64'(dones), 64'(7));
            check("b2b_ready_low_when_full", 64'(first_low_at), 64'(6));
        end

        // PHASE_CYC=3: each strobe 3 cycles, done on the 9th cycle of the sequence
        begin
            int rr_cnt = 0, f_cnt = 0, wb_cnt = 0, done_cnt = 0;
            int first_rr = -1, first_f = -1, first_wb = -1, done_idx = -1;
            do_reset();
            drive_cmd(1, 7, 8, 9, 3, 1);
            @(posedge clk);
            @(negedge clk);
            drive_cmd(0, 0, 0, 0, 0, 0);
            for (int c = 1; c <= 16; c++) begin
                @(posedge clk);
                @(negedge clk);
                if (rr3) begin rr_cnt++; if (first_rr < 0) first_rr = c; end
                if (f3)  begin f_cnt++;  if (first_f < 0)  first_f = c;  end
                if (wb3) begin wb_cnt++; if (first_wb < 0) first_wb = c; end
                if (done3) begin
                    done_cnt++;
                    done_idx = c;
                    check("p3_addr_hold", 64'({ra3, rb3, wa3, op3}),
                          64'({5'd7, 5'd8, 5'd9, 4'd3}));
                end
            end
            check("p3_rr_len", 64'(rr_cnt), 64'(3));
            check("p3_f_len", 64'(f_cnt), 64'(3));
            check("p3_wb_len", 64'(wb_cnt), 64'(3));
            check("p3_rr_start", 64'(first_rr), 64'(1));
            check("p3_f_start", 64'(first_f), 64'(4));
            check("p3_wb_start", 64'(first_wb), 64'(7));
            check("p3_done_idx", 64'(done_idx), 64'(9));
            check("p3_done_cnt", 64'(done_cnt), 64'(1));
        end

        // Asynchronous reset during EX with a second command still buffered
        begin
            int waited = 0;
            do_reset();
            drive_cmd(1, 10, 11, 12, 1, 1);
            @(posedge clk);
            @(negedge clk);
            drive_cmd(1, 20, 21, 22, 2, 1);
            @(posedge clk);
            @(negedge clk);
            drive_cmd(0, 0, 0, 0, 0, 0);
            while (!f1 && waited < 10) begin
                @(posedge clk);
                @(negedge clk);
                waited++;
            end
            check("rst_reached_ex", 64'(f1), 64'(1));
            #2;
            rst = 1'b0;
            #1;
            check("rst_strobes_low", 64'({rr1, f1, wb1, done1}), 64'(0));
            check("rst_busy_ready", 64'({busy1, rdy1}), 64'(2'b01));
            check("rst_addr_clear", 64'({ra1, rb1, wa1, op1}), 64'(0));
            @(negedge clk);
            rst = 1'b1;
            drive_cmd(1, 12, 13, 14, 5, 1);
            @(posedge clk);
            @(negedge clk);
            drive_cmd(0, 0, 0, 0, 0, 0);
            @(posedge clk);
            @(negedge clk);
            check("post_rst_rr", 64'({rr1, f1, wb1, done1, ra1, rb1, wa1, op1}),
                  64'({4'b1000, 5'd12, 5'd13, 5'd14, 4'd5}));
            repeat (2) begin
                @(posedge clk);
                @(negedge clk);
            end
            check("post_rst_wb", 64'({rr1, f1, wb1, done1}), 64'(4'b0011));
            @(posedge clk);
            @(negedge clk);
            check("post_rst_flushed", 64'({busy1, rdy1}), 64'(2'b01));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
